des_byte_host: RTL

Byte-stream host front end for `des_top`. It accepts a framed byte stream carrying mode, optional key and one 64-bit block, and assembles the 64-bit words. It issues a single-cycle request to `des_top`, waits for its result, and returns the 8 result bytes on a valid/ready output stream. It drives the core interface from the initiator side, so a narrow host link (UART/SPI bridge, scan port) can exercise the DES core without a testbench.

---
 rtl/des_byte_host_pkg.sv | 25 ++
 rtl/des_byte_pack.sv | 41 ++++
 rtl/des_byte_host.sv | 138 +++++++++++++
 3 files changed

// File: rtl/des_byte_host_pkg.sv
// Shared types and constants for the des_byte_host byte-stream front end.
package des_byte_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY,
        ST_TEXT,
        ST_ISSUE,
        ST_WAIT,
        ST_SEND
    } state_e;

    localparam int HDR_MODE       = 0;
    localparam int HDR_LOAD_KEY   = 1;
    localparam int HDR_CLR_ERR    = 7;
    localparam int BYTES_PER_WORD = 8;

    // Byte idx of a 64-bit word, MSB first (idx 0 = bits 63:56).
    function automatic logic [7:0] word_byte(input logic [63:0] w, input logic [2:0] idx);
        logic [5:0] sh;
        sh = {3'd7 - idx, 3'b000};
        return w[sh +: 8];
    endfunction

endpackage

// File: rtl/des_byte_pack.sv
// 64-bit MSB-first byte shift register with a wrapping byte count and a
// done strobe on the eighth accepted byte.
module des_byte_pack
    import des_byte_host_pkg::*;
(
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        load,
    input  logic [7:0]                  byte_in,
    output logic [BYTES_PER_WORD*8-1:0] word,
    output logic [2:0]                  cnt,
    output logic                        done
);

    logic [BYTES_PER_WORD*8-1:0] word_q, word_d;
    logic [2:0]                  cnt_q, cnt_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (load) begin
            word_d = {word_q[BYTES_PER_WORD*8-9:0], byte_in};
            cnt_d  = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word = word_q;
    assign cnt  = cnt_q;
    assign done = load && (cnt_q == 3'd7);

endmodule

// File: rtl/des_byte_host.sv
// Byte-stream host for des_top: unpacks header/key/text frames, issues one
// core request, waits (with timeout) and streams the 8 result bytes back.
module des_byte_host
    import des_byte_host_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] cipher_key,
    output logic [63:0] plain_text,
    output logic        encrypt_decrypt,
    output logic        valid_in,
    input  logic [63:0] cipher_text,
    input  logic        valid_out,
    output logic        busy,
    output logic        timeout_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_e        state_q, state_d;
    logic          mode_q, mode_d;
    logic          err_q, err_d;
    logic [63:0]   res_q, res_d;
    logic [2:0]    ocnt_q, ocnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          live_q;

    logic in_acc, out_acc, key_load, txt_load, key_done, txt_done, expire;
    logic [2:0] key_cnt, txt_cnt;

    assign in_acc   = in_valid & in_ready;
    assign out_acc  = out_valid & out_ready;
    assign key_load = in_acc && (state_q == ST_KEY);
    assign txt_load = in_acc && (state_q == ST_TEXT);
    assign expire   = (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

    des_byte_pack u_key (
        .clk     (clk),
        .rstn    (rstn),
        .load    (key_load),
        .byte_in (in_byte),
        .word    (cipher_key),
        .cnt     (key_cnt),
        .done    (key_done)
    );

    des_byte_pack u_text (
        .clk     (clk),
        .rstn    (rstn),
        .load    (txt_load),
        .byte_in (in_byte),
        .word    (plain_text),
        .cnt     (txt_cnt),
        .done    (txt_done)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        err_d   = err_q;
        res_d   = res_q;
        ocnt_d  = ocnt_q;
        tcnt_d  = tcnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_acc) begin
                    mode_d  = in_byte[HDR_MODE];
                    if (in_byte[HDR_CLR_ERR]) err_d = 1'b0;
                    state_d = in_byte[HDR_LOAD_KEY] ? ST_KEY : ST_TEXT;
                end
            end
            ST_KEY:   if (key_done) state_d = ST_TEXT;
            ST_TEXT:  if (txt_done) state_d = ST_ISSUE;
            ST_ISSUE: begin
                tcnt_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A result arriving on the expiry cycle still wins.
                if (valid_out) begin
                    res_d   = cipher_text;
                    ocnt_d  = '0;
                    state_d = ST_SEND;
                end else if (expire) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tcnt_d  = tcnt_q + 1'b1;
                end
            end
            ST_SEND: begin
                if (out_acc) begin
                    ocnt_d = ocnt_q + 3'd1;
                    if (ocnt_q == 3'd7) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // live_q keeps in_ready low while reset is held.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
            err_q   <= 1'b0;
            res_q   <= '0;
            ocnt_q  <= '0;
            tcnt_q  <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            res_q   <= res_d;
            ocnt_q  <= ocnt_d;
            tcnt_q  <= tcnt_d;
            live_q  <= 1'b1;
        end
    end

    assign in_ready        = live_q && (state_q inside {ST_IDLE, ST_KEY, ST_TEXT});
    assign valid_in        = (state_q == ST_ISSUE);
    assign out_valid       = (state_q == ST_SEND);
    assign out_byte        = out_valid ? word_byte(res_q, ocnt_q) : 8'h00;
    assign busy            = (state_q != ST_IDLE);
    assign encrypt_decrypt = mode_q;
    assign timeout_err     = err_q;

endmodule
